// File: rtl/fpu_share_arbiter_if.sv
// Handshake bundle between the requesters, the shared FPU core and
// fpu_share_arbiter.
//   req_*        : per-requester request channel (valid/ready, packed operands)
//   resp_*       : per-requester response channel (one-hot valid, shared data)
//   fpu_*        : registered operands/enable towards the FPU core, result back
//   busy_o       : arbiter not idle
// modport slave  : the arbiter side
// modport master : the requester/FPU side (testbench or cluster glue)
interface fpu_share_arbiter_if #(
  parameter int NB_REQ = 4,
  parameter int C_OP   = 32,
  parameter int C_RM   = 3,
  parameter int C_CMD  = 4
);
  localparam int IDW = $clog2(NB_REQ);

  logic [NB_REQ-1:0]       req_valid_i;
  logic [NB_REQ-1:0]       req_ready_o;
  logic [NB_REQ*C_OP-1:0]  req_op_a_i;
  logic [NB_REQ*C_OP-1:0]  req_op_b_i;
  logic [NB_REQ*C_RM-1:0]  req_rm_i;
  logic [NB_REQ*C_CMD-1:0] req_cmd_i;
  logic [NB_REQ-1:0]       resp_valid_o;
  logic [NB_REQ-1:0]       resp_ready_i;
  logic [C_OP-1:0]         resp_result_o;
  logic [IDW-1:0]          resp_id_o;
  logic [C_OP-1:0]         fpu_op_a_o;
  logic [C_OP-1:0]         fpu_op_b_o;
  logic [C_RM-1:0]         fpu_rm_o;
  logic [C_CMD-1:0]        fpu_cmd_o;
  logic                    fpu_enable_o;
  logic                    fpu_stall_o;
  logic [C_OP-1:0]         fpu_result_i;
  logic                    busy_o;

  modport slave (
    input  req_valid_i, req_op_a_i, req_op_b_i, req_rm_i, req_cmd_i,
           resp_ready_i, fpu_result_i,
    output req_ready_o, resp_valid_o, resp_result_o, resp_id_o,
           fpu_op_a_o, fpu_op_b_o, fpu_rm_o, fpu_cmd_o, fpu_enable_o,
           fpu_stall_o, busy_o
  );

  modport master (
    output req_valid_i, req_op_a_i, req_op_b_i, req_rm_i, req_cmd_i,
           resp_ready_i, fpu_result_i,
    input  req_ready_o, resp_valid_o, resp_result_o, resp_id_o,
           fpu_op_a_o, fpu_op_b_o, fpu_rm_o, fpu_cmd_o, fpu_enable_o,
           fpu_stall_o, busy_o
  );
endinterface

// File: rtl/fpu_share_arbiter.sv
// fpu_share_arbiter: shares one fixed-latency FPU core among NB_REQ
// requesters. Round-robin grant in IDLE, FPU enable held FPU_LAT cycles in
// EXEC, result returned to the issuing requester in RESP. One operation in
// flight at a time.
// Ports:
//   clk   : clock
//   rst_n : asynchronous active-low reset (aborts any in-flight operation)
//   bus   : fpu_share_arbiter_if.slave, request/response/FPU signals
module fpu_share_arbiter #(
  parameter int NB_REQ  = 4,
  parameter int C_OP    = 32,
  parameter int C_RM    = 3,
  parameter int C_CMD   = 4,
  parameter int FPU_LAT = 2
) (
  input  logic                clk,
  input  logic                rst_n,
  fpu_share_arbiter_if.slave  bus
);
  localparam int IDW = $clog2(NB_REQ);
  localparam int CW  = $clog2(FPU_LAT + 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  state_t             state_r;
  logic [IDW-1:0]     rr_ptr_r;
  logic [IDW-1:0]     owner_r;
  logic [CW-1:0]      cnt_r;
  logic [C_OP-1:0]    res_r;
  logic [C_OP-1:0]    op_a_r;
  logic [C_OP-1:0]    op_b_r;
  logic [C_RM-1:0]    rm_r;
  logic [C_CMD-1:0]   cmd_r;
  logic               enable_r;
  logic               busy_r;
  logic [NB_REQ-1:0]  resp_valid_r;

  logic               gnt_found_s;
  logic [IDW-1:0]     gnt_idx_s;
  logic [C_OP-1:0]    sel_a_s;
  logic [C_OP-1:0]    sel_b_s;
  logic [C_RM-1:0]    sel_rm_s;
  logic [C_CMD-1:0]   sel_cmd_s;

  function automatic logic [NB_REQ-1:0] onehot_f(input logic [IDW-1:0] idx);
    onehot_f = {{(NB_REQ-1){1'b0}}, 1'b1} << idx;
  endfunction

  // Round-robin search: first valid requester at or above rr_ptr, wrapping.
  always_comb begin
    int             sum_v;
    logic [IDW-1:0] idx_v;
    logic           take_v;
    gnt_found_s = 1'b0;
    gnt_idx_s   = '0;
    for (int k = 0; k < NB_REQ; k++) begin
      sum_v       = int'(rr_ptr_r) + k;
      sum_v       = (sum_v >= NB_REQ) ? (sum_v - NB_REQ) : sum_v;
      idx_v       = IDW'(sum_v);
      take_v      = !gnt_found_s && bus.req_valid_i[idx_v];
      gnt_idx_s   = take_v ? idx_v : gnt_idx_s;
      gnt_found_s = gnt_found_s | take_v;
    end
  end

  // Operand mux: pick the winner's slice out of the packed request buses.
  always_comb begin
    logic hit_v;
    sel_a_s   = '0;
    sel_b_s   = '0;
    sel_rm_s  = '0;
    sel_cmd_s = '0;
    for (int i = 0; i < NB_REQ; i++) begin
      hit_v     = (gnt_idx_s == IDW'(i));
      sel_a_s   = sel_a_s   | (bus.req_op_a_i[i*C_OP +: C_OP]   & {C_OP{hit_v}});
      sel_b_s   = sel_b_s   | (bus.req_op_b_i[i*C_OP +: C_OP]   & {C_OP{hit_v}});
      sel_rm_s  = sel_rm_s  | (bus.req_rm_i[i*C_RM +: C_RM]     & {C_RM{hit_v}});
      sel_cmd_s = sel_cmd_s | (bus.req_cmd_i[i*C_CMD +: C_CMD] & {C_CMD{hit_v}});
    end
  end

  // Grant is combinational so a requester is accepted in the cycle it asks.
  assign bus.req_ready_o = (state_r == ST_IDLE && gnt_found_s) ? onehot_f(gnt_idx_s)
                                                               : {NB_REQ{1'b0}};

  // Control FSM with its registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r      <= ST_IDLE;
      rr_ptr_r     <= '0;
      owner_r      <= '0;
      cnt_r        <= '0;
      res_r        <= '0;
      op_a_r       <= '0;
      op_b_r       <= '0;
      rm_r         <= '0;
      cmd_r        <= '0;
      enable_r     <= 1'b0;
      busy_r       <= 1'b0;
      resp_valid_r <= '0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (gnt_found_s) begin
            op_a_r   <= sel_a_s;
            op_b_r   <= sel_b_s;
            rm_r     <= sel_rm_s;
            cmd_r    <= sel_cmd_s;
            owner_r  <= gnt_idx_s;
            rr_ptr_r <= (gnt_idx_s == IDW'(NB_REQ - 1)) ? '0 : gnt_idx_s + IDW'(1);
            cnt_r    <= '0;
            enable_r <= 1'b1;
            busy_r   <= 1'b1;
            state_r  <= ST_EXEC;
          end else begin
            state_r  <= ST_IDLE;
          end
        end
        ST_EXEC: begin
          cnt_r <= cnt_r + CW'(1);
          // The FPU result is valid in the last enabled cycle; capture it then.
          if (cnt_r == CW'(FPU_LAT - 1)) begin
            res_r        <= bus.fpu_result_i;
            enable_r     <= 1'b0;
            resp_valid_r <= onehot_f(owner_r);
            state_r      <= ST_RESP;
          end else begin
            state_r      <= ST_EXEC;
          end
        end
        ST_RESP: begin
          // Only the owner's ready can release the response.
          if (bus.resp_ready_i[owner_r]) begin
            resp_valid_r <= '0;
            busy_r       <= 1'b0;
            state_r      <= ST_IDLE;
          end else begin
            state_r      <= ST_RESP;
          end
        end
        default: begin
          enable_r     <= 1'b0;
          busy_r       <= 1'b0;
          resp_valid_r <= '0;
          state_r      <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.resp_valid_o  = resp_valid_r;
  assign bus.resp_result_o = res_r;
  assign bus.resp_id_o     = owner_r;
  assign bus.fpu_op_a_o    = op_a_r;
  assign bus.fpu_op_b_o    = op_b_r;
  assign bus.fpu_rm_o      = rm_r;
  assign bus.fpu_cmd_o     = cmd_r;
  assign bus.fpu_enable_o  = enable_r;
  assign bus.fpu_stall_o   = 1'b0;
  assign bus.busy_o        = busy_r;
endmodule

// File: tb/tb_fpu_share_arbiter.sv
// Testbench for fpu_share_arbiter: a 4-requester/FPU_LAT=2 instance checked
// through grant and response scoreboards, plus a 2-requester/FPU_LAT=3
// instance checked cycle by cycle. A small FPU stand-in returns a correct
// single-precision add/mul only in the last enabled cycle, garbage otherwise.
module tb_fpu_share_arbiter;
  localparam logic [3:0] CMD_ADD = 4'd0;
  localparam logic [3:0] CMD_MUL = 4'd1;

  typedef struct {
    int          id;
    logic [31:0] res;
    int          cyc;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  int   t0, t1;
  int   en_run1, en_run2;
  exp_t gnt_q[$];
  exp_t resp_q[$];
  exp_t e_g, e_r;

  fpu_share_arbiter_if #(.NB_REQ(4), .C_OP(32), .C_RM(3), .C_CMD(4)) bus ();
  fpu_share_arbiter_if #(.NB_REQ(2), .C_OP(32), .C_RM(3), .C_CMD(4)) bus2 ();

  fpu_share_arbiter #(.NB_REQ(4), .C_OP(32), .C_RM(3), .C_CMD(4), .FPU_LAT(2)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus)
  );
  fpu_share_arbiter #(.NB_REQ(2), .C_OP(32), .C_RM(3), .C_CMD(4), .FPU_LAT(3)) dut2 (
    .clk(clk), .rst_n(rst_n), .bus(bus2)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Single precision (normal numbers only) through double-precision reals.
  function automatic logic [63:0] s2d(input logic [31:0] s);
    logic [10:0] e;
    e = {3'b000, s[30:23]} + 11'd896;
    return {s[31], e, s[22:0], 29'd0};
  endfunction

  function automatic logic [31:0] fmodel(input logic [31:0] a, input logic [31:0] b,
                                         input logic [3:0] cmd);
    real         ra, rb, rr;
    logic [63:0] d;
    logic [10:0] e;
    ra = $bitstoreal(s2d(a));
    rb = $bitstoreal(s2d(b));
    case (cmd)
      CMD_ADD: rr = ra + rb;
      CMD_MUL: rr = ra * rb;
      default: rr = 0.0;
    endcase
    d = $realtobits(rr);
    e = d[62:52] - 11'd896;
    return {d[63], e[7:0], d[51:29]};
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      en_run1 <= 0;
      en_run2 <= 0;
    end else begin
      en_run1 <= bus.fpu_enable_o ? en_run1 + 1 : 0;
      en_run2 <= bus2.fpu_enable_o ? en_run2 + 1 : 0;
    end
  end

  assign bus.fpu_result_i = (bus.fpu_enable_o && en_run1 == 1)
      ? fmodel(bus.fpu_op_a_o, bus.fpu_op_b_o, bus.fpu_cmd_o) : 32'hDEAD_BEEF;
  assign bus2.fpu_result_i = (bus2.fpu_enable_o && en_run2 == 2)
      ? fmodel(bus2.fpu_op_a_o, bus2.fpu_op_b_o, bus2.fpu_cmd_o) : 32'hDEAD_BEEF;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic set_req(input int i, input logic [31:0] a, input logic [31:0] b,
                         input logic [3:0] cmd);
    bus.req_op_a_i[i*32 +: 32] = a;
    bus.req_op_b_i[i*32 +: 32] = b;
    bus.req_rm_i[i*3 +: 3]     = 3'd0;
    bus.req_cmd_i[i*4 +: 4]    = cmd;
  endtask

  task automatic push(input int id, input int gcyc, input logic [31:0] res, input int rcyc,
                      input bit with_resp);
    exp_t g, r;
    g.id = id; g.res = 32'd0; g.cyc = gcyc;
    gnt_q.push_back(g);
    if (with_resp) begin
      r.id = id; r.res = res; r.cyc = rcyc;
      resp_q.push_back(r);
    end
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_req_ready"},   64'(bus.req_ready_o),   64'h0);
    chk({tag, "_resp_valid"},  64'(bus.resp_valid_o),  64'h0);
    chk({tag, "_resp_result"}, 64'(bus.resp_result_o), 64'h0);
    chk({tag, "_resp_id"},     64'(bus.resp_id_o),     64'h0);
    chk({tag, "_fpu_enable"},  64'(bus.fpu_enable_o),  64'h0);
    chk({tag, "_fpu_stall"},   64'(bus.fpu_stall_o),   64'h0);
    chk({tag, "_busy"},        64'(bus.busy_o),        64'h0);
    chk({tag, "_op_a"},        64'(bus.fpu_op_a_o),    64'h0);
    chk({tag, "_op_b"},        64'(bus.fpu_op_b_o),    64'h0);
    chk({tag, "_cmd"},         64'(bus.fpu_cmd_o),     64'h0);
    chk({tag, "_dut2_busy"},   64'(bus2.busy_o),       64'h0);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Monitor: pops the scoreboards whenever a grant or a completed response appears.
  always @(negedge clk) begin
    if (rst_n) begin
      if (bus.req_ready_o != 4'b0000) begin
        checks++;
        if (gnt_q.size() == 0) begin
          errors++;
          $display("FAIL grant_unexpected actual=%b required=none (cycle %0d)", bus.req_ready_o, cyc);
        end else begin
          e_g = gnt_q.pop_front();
          if (bus.req_ready_o !== (4'b0001 << e_g.id) || cyc != e_g.cyc) begin
            errors++;
            $display("FAIL grant actual=%b@%0d required=%b@%0d", bus.req_ready_o, cyc,
                     4'b0001 << e_g.id, e_g.cyc);
          end
        end
      end
      if (bus.resp_valid_o != 4'b0000 && bus.resp_ready_i[bus.resp_id_o]) begin
        checks++;
        if (resp_q.size() == 0) begin
          errors++;
          $display("FAIL resp_unexpected actual=%b id=%0d required=none (cycle %0d)",
                   bus.resp_valid_o, bus.resp_id_o, cyc);
        end else begin
          e_r = resp_q.pop_front();
          if (bus.resp_valid_o !== (4'b0001 << e_r.id) || int'(bus.resp_id_o) != e_r.id ||
              bus.resp_result_o !== e_r.res || cyc != e_r.cyc) begin
            errors++;
            $display("FAIL resp actual=%b/id%0d/%h@%0d required=%b/id%0d/%h@%0d",
                     bus.resp_valid_o, bus.resp_id_o, bus.resp_result_o, cyc,
                     4'b0001 << e_r.id, e_r.id, e_r.res, e_r.cyc);
          end
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n = 1'b0;
    bus.req_valid_i = 4'b0000; bus.req_op_a_i = '0; bus.req_op_b_i = '0;
    bus.req_rm_i = '0; bus.req_cmd_i = '0; bus.resp_ready_i = 4'b1111;
    bus2.req_valid_i = 2'b00; bus2.req_op_a_i = '0; bus2.req_op_b_i = '0;
    bus2.req_rm_i = '0; bus2.req_cmd_i = '0; bus2.resp_ready_i = 2'b11;
    @(negedge clk);
    chk_reset_outputs("rst");
    tick();
    rst_n = 1'b1;
    @(negedge clk);
    chk_reset_outputs("rel");

    // Single request from requester 2: 1.0 + 2.0.
    tick();
    t0 = cyc;
    set_req(2, 32'h3F80_0000, 32'h4000_0000, CMD_ADD);
    bus.req_valid_i = 4'b0100;
    push(2, t0, 32'h4040_0000, t0 + 3, 1'b1);
    @(negedge clk);
    chk("single_ready", 64'(bus.req_ready_o), 64'h4);
    chk("single_busy_t0", 64'(bus.busy_o), 64'h0);
    tick();
    bus.req_valid_i = 4'b0000;
    @(negedge clk);
    chk("single_en_t1", 64'(bus.fpu_enable_o), 64'h1);
    chk("single_op_a", 64'(bus.fpu_op_a_o), 64'h3F80_0000);
    chk("single_op_b", 64'(bus.fpu_op_b_o), 64'h4000_0000);
    chk("single_busy_t1", 64'(bus.busy_o), 64'h1);
    @(negedge clk);
    chk("single_en_t2", 64'(bus.fpu_enable_o), 64'h1);
    @(negedge clk);
    chk("single_en_t3", 64'(bus.fpu_enable_o), 64'h0);
    chk("single_resp_valid", 64'(bus.resp_valid_o), 64'h4);
    chk("single_resp_id", 64'(bus.resp_id_o), 64'h2);
    chk("single_resp_result", 64'(bus.resp_result_o), 64'h4040_0000);
    @(negedge clk);
    chk("single_resp_done", 64'(bus.resp_valid_o), 64'h0);
    chk("single_busy_t4", 64'(bus.busy_o), 64'h0);

    // All four requesting from reset: grants 0,1,2,3,0 every 4 cycles.
    tick();
    rst_n = 1'b0;
    repeat (2) tick();
    rst_n = 1'b1;
    t0 = cyc;
    set_req(0, 32'h3F80_0000, 32'h4000_0000, CMD_ADD);
    set_req(1, 32'h4000_0000, 32'h4040_0000, CMD_MUL);
    set_req(2, 32'h3FC0_0000, 32'h3F00_0000, CMD_ADD);
    set_req(3, 32'h3FC0_0000, 32'h3FC0_0000, CMD_MUL);
    bus.req_valid_i = 4'b1111;
    push(0, t0,      32'h4040_0000, t0 + 3,  1'b1);
    push(1, t0 + 4,  32'h40C0_0000, t0 + 7,  1'b1);
    push(2, t0 + 8,  32'h4000_0000, t0 + 11, 1'b1);
    push(3, t0 + 12, 32'h4010_0000, t0 + 15, 1'b1);
    push(0, t0 + 16, 32'h4040_0000, t0 + 19, 1'b1);
    repeat (17) tick();
    bus.req_valid_i = 4'b0000;
    repeat (4) tick();

    // Requester 1 stalls its response 5 cycles; requester 0 waits meanwhile,
    // then requester 3's ready is ignored while requester 0 owns the response.
    t0 = cyc;
    bus.resp_ready_i = 4'b1101;
    bus.req_valid_i = 4'b0010;
    push(1, t0, 32'h40C0_0000, t0 + 8, 1'b1);
    tick();
    bus.req_valid_i = 4'b0001;
    push(0, t0 + 9, 32'h4040_0000, t0 + 14, 1'b1);
    repeat (2) @(posedge clk);
    for (int k = 3; k <= 7; k++) begin
      @(negedge clk);
      chk("stall_resp_valid", 64'(bus.resp_valid_o), 64'h2);
      chk("stall_resp_result", 64'(bus.resp_result_o), 64'h40C0_0000);
      chk("stall_no_ready", 64'(bus.req_ready_o), 64'h0);
    end
    tick();
    bus.resp_ready_i = 4'b1010;
    @(negedge clk);
    tick();
    @(negedge clk);
    chk("idle_after_stall_busy", 64'(bus.busy_o), 64'h0);
    tick();
    bus.req_valid_i = 4'b0000;
    repeat (2) @(posedge clk);
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      chk("foreign_ready_resp_valid", 64'(bus.resp_valid_o), 64'h1);
      chk("foreign_ready_busy", 64'(bus.busy_o), 64'h1);
    end
    tick();
    bus.resp_ready_i = 4'b1111;
    repeat (2) tick();

    // Reset during EXEC: operation dropped, round-robin restarts at 0.
    t0 = cyc;
    bus.req_valid_i = 4'b0100;
    push(2, t0, 32'h0, 0, 1'b0);
    tick();
    bus.req_valid_i = 4'b0000;
    #2;
    rst_n = 1'b0;
    @(negedge clk);
    chk_reset_outputs("abort");
    repeat (2) tick();
    rst_n = 1'b1;
    t1 = cyc;
    bus.req_valid_i = 4'b1010;
    push(1, t1,     32'h40C0_0000, t1 + 3, 1'b1);
    push(3, t1 + 4, 32'h4010_0000, t1 + 7, 1'b1);
    tick();
    bus.req_valid_i = 4'b1000;
    repeat (4) tick();
    bus.req_valid_i = 4'b0000;
    repeat (4) tick();

    // NB_REQ=2, FPU_LAT=3 instance: 1.0 + 1.0 from requester 1.
    t0 = cyc;
    bus2.req_op_a_i[63:32] = 32'h3F80_0000;
    bus2.req_op_b_i[63:32] = 32'h3F80_0000;
    bus2.req_cmd_i[7:4]    = CMD_ADD;
    bus2.req_valid_i       = 2'b10;
    @(negedge clk);
    chk("lat3_ready", 64'(bus2.req_ready_o), 64'h2);
    tick();
    bus2.req_valid_i = 2'b00;
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      chk("lat3_enable", 64'(bus2.fpu_enable_o), (k <= 3) ? 64'h1 : 64'h0);
      chk("lat3_resp_valid", 64'(bus2.resp_valid_o), (k == 4) ? 64'h2 : 64'h0);
    end
    chk("lat3_resp_id", 64'(bus2.resp_id_o), 64'h1);
    chk("lat3_resp_result", 64'(bus2.resp_result_o), 64'h4000_0000);
    repeat (2) tick();

    chk("grants_outstanding", 64'(gnt_q.size()), 64'h0);
    chk("responses_outstanding", 64'(resp_q.size()), 64'h0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
